ex_flag_branch: RTL

- EX/MEM boundary stage directly downstream of the 16-bit ALU.
- Registers the ALU result and destination info into the MEM stage.
- Holds architectural N/Z/V flags in real flops, replacing the ALU's combinational hold paths.
- Evaluates conditional branches against the held flags and drives a front-end redirect/squash sequence through a small FSM.

---
 rtl/ex_flag_branch.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/ex_flag_branch.sv
// EX/MEM boundary stage: registers ALU result, holds N/Z/V flags, resolves branches.
// Latency: 1 cycle from an accepted EX instruction to the MEM register, flags and redirect.
// Backpressure: stall freezes all state; a taken branch squashes EX inputs for SQUASH_CYC unstalled cycles.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset (rst wins over stall)
//   stall              freeze every register this cycle
//   ex_*, alu_*        EX-slot instruction, ALU control/result and raw ALU flags
//   br_cond, br_target branch condition code and resolved target PC
//   mem_*              registered MEM-slot outputs
//   flag_n/z/v         architectural flags
//   redirect(_pc)      fetch redirect request and target
//   flush_front        IF/ID squash while the redirect sequence runs
//   br_taken_cnt       saturating taken-branch counter, present only when
//                      EX_BR_PERF_CNT_EN is defined
module ex_flag_branch #(
    parameter int Nb         = 16,
    parameter int SQUASH_CYC = 2    // flush length after a taken branch, 1..7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          ex_valid,
    input  logic          ex_is_alu,
    input  logic [3:0]    alu_sigs,
    input  logic [Nb-1:0] alu_out,
    input  logic          alu_n,
    input  logic          alu_z,
    input  logic          alu_v,
    input  logic [3:0]    ex_rd,
    input  logic          ex_we,
    input  logic          ex_is_br,
    input  logic [2:0]    br_cond,
    input  logic [Nb-1:0] br_target,
    output logic          mem_valid,
    output logic [Nb-1:0] mem_data,
    output logic [3:0]    mem_rd,
    output logic          mem_we,
    output logic          flag_n,
    output logic          flag_z,
    output logic          flag_v,
    output logic          redirect,
    output logic [Nb-1:0] redirect_pc,
    output logic          flush_front
`ifdef EX_BR_PERF_CNT_EN
    ,
    output logic [15:0]   br_taken_cnt
`endif
);

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_t;

    localparam logic [2:0] SQ_INIT = 3'(SQUASH_CYC);

    state_t          state, state_nxt;
    logic [2:0]      cnt, cnt_nxt;
    logic            redirect_nxt;
    logic [Nb-1:0]   redirect_pc_nxt;

    logic            acc;
    logic            set_nv;
    logic            cond_met;
    logic            br_take;

    // s0 does not influence flag or branch behaviour at this stage.
    logic            unused_sig;
    assign unused_sig = alu_sigs[0];

    // Instructions seen while squashing are wrong-path and must have no effect.
    assign acc    = ex_valid & ~stall & (state == RUN);
    // Only ADD/SUB produce meaningful N and V.
    assign set_nv = ~alu_sigs[3] & alu_sigs[2] & ~alu_sigs[1];

    // Conditions read the flags as registered before this edge, so an ALU op
    // fused with a branch is evaluated against the previous result.
    always_comb begin
        cond_met = 1'b0;
        case (br_cond)
            3'b000:  cond_met = ~flag_z;
            3'b001:  cond_met = flag_z;
            3'b010:  cond_met = ~flag_z & ~flag_n;
            3'b011:  cond_met = flag_n;
            3'b100:  cond_met = flag_z | ~flag_n;
            3'b101:  cond_met = flag_n | flag_z;
            3'b110:  cond_met = flag_v;
            default: cond_met = 1'b1;
        endcase
    end

    assign br_take = acc & ex_is_br & cond_met;

    // Redirect FSM next-state logic.
    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        redirect_nxt    = redirect;
        redirect_pc_nxt = redirect_pc;
        case (state)
            RUN: begin
                if (br_take) begin
                    state_nxt       = SQUASH;
                    cnt_nxt         = SQ_INIT;
                    redirect_nxt    = 1'b1;
                    redirect_pc_nxt = br_target;
                end
            end
            SQUASH: begin
                if (!stall) begin
                    redirect_nxt = 1'b0;
                    // <= 1 rather than == 1 keeps cnt from ever wrapping.
                    if (cnt <= 3'd1) begin
                        state_nxt = RUN;
                        cnt_nxt   = 3'd0;
                    end else begin
                        cnt_nxt = cnt - 3'd1;
                    end
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            cnt         <= 3'd0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            redirect    <= redirect_nxt;
            redirect_pc <= redirect_pc_nxt;
        end
    end

    assign flush_front = (state == SQUASH);

    // MEM register; branches occupy no MEM slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid <= 1'b0;
            mem_data  <= '0;
            mem_rd    <= 4'd0;
            mem_we    <= 1'b0;
        end else if (!stall) begin
            mem_valid <= acc & ~ex_is_br;
            mem_data  <= alu_out;
            mem_rd    <= ex_rd;
            mem_we    <= acc & ~ex_is_br & ex_we;
        end
    end

    // Architectural flags: Z on every ALU op, N/V only on ADD/SUB.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_n <= 1'b0;
            flag_z <= 1'b0;
            flag_v <= 1'b0;
        end else if (acc & ex_is_alu) begin
            flag_z <= alu_z;
            if (set_nv) begin
                flag_n <= alu_n;
                flag_v <= alu_v;
            end
        end
    end

`ifdef EX_BR_PERF_CNT_EN
    // Saturating count of taken branches; br_take already excludes stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_taken_cnt <= 16'd0;
        end else if (br_take && (br_taken_cnt != 16'hFFFF)) begin
            br_taken_cnt <= br_taken_cnt + 16'd1;
        end
    end
`endif

endmodule
